memory_arbiter: RTL and testbench

Sequences the single unified RAM port between the instruction fetch path and the data path of the MIPS core. Grants one requester at a time through a small FSM and returns the RAM word and per-requester wait signals. Data requests have priority, bounded by a starvation guard that forces an instruction grant after a run of back-to-back data grants. It sits between the datapath cache signals (ihit/dhit are derived from its wait outputs) and the RAM model.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/arbiter_if.sv | 32 +++
 rtl/arb_stat_counter.sv | 32 +++
 rtl/memory_arbiter.sv | 145 ++++++++++++++
 tb/tb_memory_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared core types (RAM handshake state, machine word) plus
// the arbiter state encoding and its starvation-guard helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } arbstate_t;

  // Saturating increment of the data-grant streak counter.
  function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] max);
    logic [3:0] nxt;
    if (cur >= max) begin
      nxt = max;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/arbiter_if.sv
// arbiter_if: groups the fetch, data and RAM sides of the memory arbiter.
interface arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic [1:0] ramstate;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_stat_counter.sv
// arb_stat_counter: enable-gated 32-bit event counter that wraps at 2^32.
module arb_stat_counter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Count one event per enabled cycle; natural overflow gives the wrap.
  always_comb begin
    if (en) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: sequences the unified RAM port between instruction fetch
// and data accesses. Data has priority, limited by a streak guard that
// forces an instruction grant after DSTREAK_MAX data grants in a row.
// Optional build macro MEMORY_ARBITER_STATS_EN adds igrant_cnt, dgrant_cnt
// and stall_cnt outputs.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEMORY_ARBITER_STATS_EN
  ,
  output logic [31:0] igrant_cnt,
  output logic [31:0] dgrant_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] STREAK_MAX = DSTREAK_MAX[3:0];

  arbstate_t  state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       dreq_s;
  logic       ram_access_s;
  logic       icomp_s;
  logic       dcomp_s;

  assign dreq_s       = dREN | dWEN;
  assign ram_access_s = (ramstate == ACCESS);

  // Next-state, streak update and RAM strobes; strobes follow the live
  // request so a withdrawn request drops them in the same cycle.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    icomp_s  = 1'b0;
    dcomp_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq_s && ((streak_q < STREAK_MAX) || !iREN)) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end else begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_access_s) begin
            icomp_s  = 1'b1;
            state_d  = IDLE;
            streak_d = 4'd0;
          end else begin
            state_d = IGRANT;
          end
        end
      end
      DGRANT: begin
        if (!dreq_s) begin
          state_d = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_access_s) begin
            dcomp_s = 1'b1;
            state_d = IDLE;
            if (iREN) begin
              streak_d = streak_inc(streak_q, STREAK_MAX);
            end else begin
              streak_d = 4'd0;
            end
          end else begin
            state_d = DGRANT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Wait and load outputs: loads are only non-zero on the completing cycle.
  always_comb begin
    iwait = iREN & ~icomp_s;
    dwait = dreq_s & ~dcomp_s;
    if (icomp_s) begin
      iload = ramload;
    end else begin
      iload = 32'h0000_0000;
    end
    if (dcomp_s) begin
      dload = ramload;
    end else begin
      dload = 32'h0000_0000;
    end
  end

  // Arbiter state and streak registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

`ifdef MEMORY_ARBITER_STATS_EN
  arb_stat_counter u_igrant_cnt (.CLK(CLK), .RST(RST), .en(icomp_s),       .cnt(igrant_cnt));
  arb_stat_counter u_dgrant_cnt (.CLK(CLK), .RST(RST), .en(dcomp_s),       .cnt(dgrant_cnt));
  arb_stat_counter u_stall_cnt  (.CLK(CLK), .RST(RST), .en(iwait | dwait), .cnt(stall_cnt));
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level reference model of the arbiter.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = 32'h0, daddr = 32'h0, dstore = 32'h0, ramload = 32'h0;
  logic [1:0]  ramstate = 2'b00;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEMORY_ARBITER_STATS_EN
  logic [31:0] igrant_cnt, dgrant_cnt, stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.DSTREAK_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEMORY_ARBITER_STATS_EN
    , .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Reference model: who owns the RAM port (0 none, 1 fetch, 2 data) and how
  // many data grants have gone by while fetch was waiting.
  int   m_owner  = 0;
  int   m_streak = 0;
  logic r_dq, r_gi, r_gd, r_acc;
  logic e_ren, e_wen, e_iwait, e_dwait;
  logic [31:0] e_addr, e_store, e_iload, e_dload;

  // Expected outputs for the current cycle from the owner and live inputs.
  always_comb begin
    r_dq    = dREN | dWEN;
    r_gi    = (m_owner == 1) && iREN;
    r_gd    = (m_owner == 2) && r_dq;
    r_acc   = (ramstate == ACCESS);
    e_ren   = r_gi || (r_gd && !dWEN);
    e_wen   = r_gd && dWEN;
    e_addr  = r_gi ? iaddr : (r_gd ? daddr : 32'h0);
    e_store = r_gd ? dstore : 32'h0;
    e_iwait = iREN && !(r_gi && r_acc);
    e_dwait = r_dq && !(r_gd && r_acc);
    e_iload = (r_gi && r_acc) ? ramload : 32'h0;
    e_dload = (r_gd && r_acc) ? ramload : 32'h0;
  end

  // Model ownership transitions at each clock edge.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_owner  <= 0;
      m_streak <= 0;
    end else if (m_owner == 0) begin
      if (r_dq && (m_streak < 4 || !iREN)) m_owner <= 2;
      else if (iREN) m_owner <= 1;
    end else if (m_owner == 1) begin
      if (!iREN) m_owner <= 0;
      else if (r_acc) begin
        m_owner  <= 0;
        m_streak <= 0;
      end
    end else begin
      if (!r_dq) m_owner <= 0;
      else if (r_acc) begin
        m_owner  <= 0;
        m_streak <= iREN ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0; ramstate = ACCESS; ramload = 32'h1234_5678;
    #1;
    total++;
    if ({ramREN, ramWEN, ramaddr, ramstore} !== {1'b0, 1'b0, 32'h0, 32'h0})
      $display("FAIL reset_strobes: got %b %b %h %h, expected 0 0 0 0", ramREN, ramWEN, ramaddr, ramstore);
    else passed++;
    total++;
    if ({iload, dload, iwait, dwait} !== {32'h0, 32'h0, 1'b1, 1'b0})
      $display("FAIL reset_wait_load: got %h %h %b %b, expected 0 0 1 0", iload, dload, iwait, dwait);
    else passed++;
    @(negedge CLK);
    RST = 1'b0; iREN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_instr_fetch();
    do_reset();
    @(negedge CLK); iREN = 1'b1; iaddr = 32'h40; ramstate = FREE; ramload = 32'h0; #1;
    total++;
    if ({ramREN, iwait} !== 2'b01) $display("FAIL ifetch_idle: got ren=%b iwait=%b, expected 0 1", ramREN, iwait);
    else passed++;
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h8C22_0004; #1;
    total++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h40}) $display("FAIL ifetch_grant: got ren=%b addr=%h, expected 1 40", ramREN, ramaddr);
    else passed++;
    total++;
    if ({iwait, iload} !== {1'b0, 32'h8C22_0004}) $display("FAIL ifetch_data: got iwait=%b iload=%h, expected 0 8c220004", iwait, iload);
    else passed++;
    @(negedge CLK); #1;
    total++;
    if ({ramREN, iwait, iload} !== {1'b0, 1'b1, 32'h0}) $display("FAIL ifetch_dead_cycle: got ren=%b iwait=%b iload=%h, expected 0 1 0", ramREN, iwait, iload);
    else passed++;
    @(negedge CLK); iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
  endtask

  task automatic test_data_write_busy();
    do_reset();
    @(negedge CLK); dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = BUSY; #1;
    total++;
    if ({ramWEN, dwait} !== 2'b01) $display("FAIL dwrite_idle: got wen=%b dwait=%b, expected 0 1", ramWEN, dwait);
    else passed++;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK); #1;
      total++;
      if ({ramWEN, ramREN, ramaddr, ramstore, dwait} !== {1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1})
        $display("FAIL dwrite_busy%0d: got wen=%b ren=%b addr=%h store=%h dwait=%b, expected 1 0 100 deadbeef 1",
                 k, ramWEN, ramREN, ramaddr, ramstore, dwait);
      else passed++;
    end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h1234_5678; #1;
    total++;
    if ({ramWEN, ramaddr, ramstore, dwait, dload} !== {1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678})
      $display("FAIL dwrite_access: got wen=%b addr=%h store=%h dwait=%b dload=%h, expected 1 100 deadbeef 0 12345678",
               ramWEN, ramaddr, ramstore, dwait, dload);
    else passed++;
    @(negedge CLK); dWEN = 1'b0; #1;
    total++;
    if ({ramWEN, dwait} !== 2'b00) $display("FAIL dwrite_done: got wen=%b dwait=%b, expected 0 0", ramWEN, dwait);
    else passed++;
  endtask

  task automatic test_streak();
    string exp_order = "DDDDIDDDDI";
    byte   got[10];
    int    n = 0;
    do_reset();
    iaddr = 32'h1000; daddr = 32'h2000; ramstate = ACCESS;
    @(negedge CLK); iREN = 1'b1; dREN = 1'b1;
    for (int c = 0; c < 40 && n < 10; c++) begin
      #1;
      if (!iwait) begin got[n] = "I"; n++; end
      else if (!dwait) begin got[n] = "D"; n++; end
      @(negedge CLK);
    end
    iREN = 1'b0; dREN = 1'b0;
    total++;
    if (n !== 10) $display("FAIL streak_count: got %0d completions, expected 10", n);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (k >= n || got[k] !== exp_order[k])
        $display("FAIL streak_order[%0d]: got %c, expected %c", k, (k < n) ? got[k] : 8'h3f, exp_order[k]);
      else passed++;
    end
    @(negedge CLK);
  endtask

  task automatic test_withdraw();
    do_reset();
    @(negedge CLK); iREN = 1'b1; dREN = 1'b1; iaddr = 32'h80; daddr = 32'h300; ramstate = BUSY; #1;
    @(negedge CLK); #1;
    total++;
    if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h300, 1'b1}) $display("FAIL withdraw_grant: got ren=%b addr=%h dwait=%b, expected 1 300 1", ramREN, ramaddr, dwait);
    else passed++;
    dREN = 1'b0; #1;
    total++;
    if ({ramREN, dwait, dload, iwait} !== {1'b0, 1'b0, 32'h0, 1'b1}) $display("FAIL withdraw_drop: got ren=%b dwait=%b dload=%h iwait=%b, expected 0 0 0 1", ramREN, dwait, dload, iwait);
    else passed++;
    @(negedge CLK); #1;
    total++;
    if (ramREN !== 1'b0) $display("FAIL withdraw_idle: got ren=%b, expected 0", ramREN);
    else passed++;
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h0000_A5A5; #1;
    total++;
    if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h80, 1'b0, 32'h0000_A5A5}) $display("FAIL withdraw_igrant: got ren=%b addr=%h iwait=%b iload=%h, expected 1 80 0 a5a5", ramREN, ramaddr, iwait, iload);
    else passed++;
    @(negedge CLK); iREN = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    @(negedge CLK); iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY; #1;
    @(negedge CLK); #1;
    total++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h44}) $display("FAIL rstmid_grant: got ren=%b addr=%h, expected 1 44", ramREN, ramaddr);
    else passed++;
    RST = 1'b1; #1;
    total++;
    if ({ramREN, ramaddr, iload, iwait} !== {1'b0, 32'h0, 32'h0, 1'b1}) $display("FAIL rstmid_drop: got ren=%b addr=%h iload=%h iwait=%b, expected 0 0 0 1", ramREN, ramaddr, iload, iwait);
    else passed++;
    @(negedge CLK); RST = 1'b0; #1;
    total++;
    if (ramREN !== 1'b0) $display("FAIL rstmid_idle: got ren=%b, expected 0", ramREN);
    else passed++;
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h77; #1;
    total++;
    if ({ramREN, iwait, iload} !== {1'b1, 1'b0, 32'h77}) $display("FAIL rstmid_regrant: got ren=%b iwait=%b iload=%h, expected 1 0 77", ramREN, iwait, iload);
    else passed++;
    @(negedge CLK); iREN = 1'b0;
  endtask

  task automatic test_random();
    logic iw = 1'b0, dw = 1'b0, wsel = 1'b0, rsel = 1'b0;
    int   k;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (iw && $urandom_range(0, 15) == 0) iw = 1'b0;
      if (dw && $urandom_range(0, 15) == 0) dw = 1'b0;
      if (!iw && $urandom_range(0, 2) == 0) begin iw = 1'b1; iaddr = $urandom; end
      if (!dw && $urandom_range(0, 2) == 0) begin
        dw = 1'b1; daddr = $urandom; dstore = $urandom;
        k = $urandom_range(0, 4);
        wsel = (k >= 2); rsel = (k <= 1) || (k == 4);
      end
      iREN = iw; dREN = dw & rsel; dWEN = dw & wsel;
      ramstate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) ramstate = ACCESS;
      ramload = $urandom;
      #1;
      total++;
      if ({ramREN, ramWEN, iwait, dwait, ramaddr, ramstore, iload, dload} !==
          {e_ren, e_wen, e_iwait, e_dwait, e_addr, e_store, e_iload, e_dload})
        $display("FAIL random_cycle%0d: got ren=%b wen=%b iw=%b dw=%b addr=%h st=%h il=%h dl=%h, expected %b %b %b %b %h %h %h %h",
                 c, ramREN, ramWEN, iwait, dwait, ramaddr, ramstore, iload, dload,
                 e_ren, e_wen, e_iwait, e_dwait, e_addr, e_store, e_iload, e_dload);
      else passed++;
      if (iREN && !e_iwait) iw = 1'b0;
      if (r_dq && !e_dwait) dw = 1'b0;
    end
    @(negedge CLK); iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

`ifdef MEMORY_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int f = 0; f < 5; f++) begin
      @(negedge CLK); iREN = 1'b1; iaddr = 32'(f * 4); ramstate = BUSY;
      @(negedge CLK); ramstate = BUSY;
      @(negedge CLK); ramstate = ACCESS;
      @(negedge CLK); iREN = 1'b0; ramstate = FREE;
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge CLK); dREN = 1'b1; daddr = 32'(d * 8); ramstate = ACCESS;
      @(negedge CLK); ramstate = ACCESS;
      @(negedge CLK); dREN = 1'b0; ramstate = FREE;
    end
    @(negedge CLK); #1;
    total++;
    if (igrant_cnt !== 32'd5) $display("FAIL stats_igrant: got %0d, expected 5", igrant_cnt);
    else passed++;
    total++;
    if (dgrant_cnt !== 32'd3) $display("FAIL stats_dgrant: got %0d, expected 3", dgrant_cnt);
    else passed++;
    total++;
    if (stall_cnt !== 32'd13) $display("FAIL stats_stall: got %0d, expected 13", stall_cnt);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_instr_fetch();
    test_data_write_busy();
    test_streak();
    test_withdraw();
    test_reset_mid_grant();
    test_random();
`ifdef MEMORY_ARBITER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
